bcd_seg7_display: RTL and testbench

//   Reader end of the calculator's operand/result register path. Takes the N-bit

---
 rtl/bcd_seg7_display_pkg.sv | 39 +++
 rtl/bcd_seg7_display_seg7_decode.sv | 27 ++
 rtl/bcd_seg7_display.sv | 143 ++++++++++++++
 tb/tb_bcd_seg7_display.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_seg7_display_pkg.sv
// Shared constants, FSM state type and double-dabble helper for the
// calculator result display path.
package bcd_seg7_display_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } conv_state_e;

    localparam int BCD_W = 16;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [BCD_W-1:0] dabble_adjust(
        input logic [BCD_W-1:0] bcd
    );
        logic [BCD_W-1:0] r;
        r = bcd;
        for (int i = 0; i < 4; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_seg7_display_seg7_decode.sv
// Combinational BCD digit to active-low 7-segment pattern.
// Non-decimal nibbles decode to all segments off.
module seg7_decode
    import bcd_seg7_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_BLANK;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/bcd_seg7_display.sv
// Binary register value -> 4-digit BCD via sequential double-dabble,
// scanned onto a common-anode 7-segment display.
module bcd_seg7_display
    import bcd_seg7_display_pkg::*;
#(
    parameter int N        = 8,
    parameter int SCAN_DIV = 50000,
    parameter bit BLANK_LZ = 1'b1
)
(
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] value,
    output logic         busy,
    output logic [3:0]   an,
    output logic [6:0]   seg,
    output logic         dp
);

    localparam int SW = N + BCD_W;
    localparam int CW = $clog2(N + 1);
    localparam int DW = $clog2(SCAN_DIV);

    if (N < 1 || N > 13) begin : g_bad_n
        $error("bcd_seg7_display: N must be 1..13");
    end
    if (SCAN_DIV < 2) begin : g_bad_div
        $error("bcd_seg7_display: SCAN_DIV must be >= 2");
    end

    conv_state_e state_q, state_d;
    logic             force_q, force_d;
    logic [N-1:0]     last_q, last_d;
    logic [SW-1:0]    sh_q, sh_d;
    logic [SW-1:0]    sh_adj;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [BCD_W-1:0] shown_q, shown_d;
    logic [DW-1:0]    scan_q, scan_d;
    logic [1:0]       idx_q, idx_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic [3:0]       nib;
    logic [6:0]       dec_seg;
    logic [3:0]       lz;
    logic             blank;

    always_comb begin
        state_d = state_q;
        force_d = force_q;
        last_d  = last_q;
        sh_d    = sh_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        shown_d = shown_q;
        sh_adj  = {dabble_adjust(sh_q[SW-1:N]), sh_q[N-1:0]};
        unique case (state_q)
            IDLE: begin
                if (force_q || (value != last_q)) begin
                    sh_d    = {{BCD_W{1'b0}}, value};
                    last_d  = value;
                    busy_d  = 1'b1;
                    force_d = 1'b0;
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                sh_d  = {sh_adj[SW-2:0], 1'b0};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                shown_d = sh_q[SW-1:N];
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Scan timing is free-running so every digit gets the same dwell.
    always_comb begin
        scan_d = scan_q + 1'b1;
        idx_d  = idx_q;
        if (scan_q == DW'(SCAN_DIV - 1)) begin
            scan_d = '0;
            idx_d  = idx_q + 1'b1;
        end
    end

    always_comb begin
        lz[3] = (shown_q[15:12] == 4'd0);
        lz[2] = lz[3] && (shown_q[11:8] == 4'd0);
        lz[1] = lz[2] && (shown_q[7:4] == 4'd0);
        lz[0] = 1'b0;
        nib   = shown_q[4*idx_q +: 4];
        blank = BLANK_LZ && lz[idx_q];
        an_d  = ~(4'b0001 << idx_q);
        seg_d = blank ? SEG_BLANK : dec_seg;
    end

    seg7_decode u_dec (
        .digit (nib),
        .seg   (dec_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            force_q <= 1'b1;
            last_q  <= '0;
            sh_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            shown_q <= '0;
            scan_q  <= '0;
            idx_q   <= '0;
            an_q    <= 4'hF;
            seg_q   <= SEG_BLANK;
        end else begin
            state_q <= state_d;
            force_q <= force_d;
            last_q  <= last_d;
            sh_q    <= sh_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            shown_q <= shown_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign busy = busy_q;
    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = 1'b1;

endmodule

// File: tb/tb_bcd_seg7_display.sv
// Scoreboard bench for bcd_seg7_display: three instances cover
// N=8 blanked, N=8 unblanked and N=13, all with SCAN_DIV=4.
module tb_bcd_seg7_display;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  v8  = '0;
    logic [12:0] v13 = '0;

    logic       busy8, busy_nb, busy13;
    logic [3:0] an8, an_nb, an13;
    logic [6:0] seg8, seg_nb, seg13;
    logic       dp8, dp_nb, dp13;

    int vectors = 0;
    int errors  = 0;

    typedef struct {
        int          inst;
        logic [27:0] segs;
        int          val;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_seg7_display #(.N(8), .SCAN_DIV(4), .BLANK_LZ(1'b1)) dut (
        .clk(clk), .rst(rst), .value(v8),
        .busy(busy8), .an(an8), .seg(seg8), .dp(dp8)
    );

    bcd_seg7_display #(.N(8), .SCAN_DIV(4), .BLANK_LZ(1'b0)) dut_nb (
        .clk(clk), .rst(rst), .value(v8),
        .busy(busy_nb), .an(an_nb), .seg(seg_nb), .dp(dp_nb)
    );

    bcd_seg7_display #(.N(13), .SCAN_DIV(4), .BLANK_LZ(1'b1)) dut13 (
        .clk(clk), .rst(rst), .value(v13),
        .busy(busy13), .an(an13), .seg(seg13), .dp(dp13)
    );

    function automatic logic [6:0] seg_of(int d);
        case (d)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [27:0] exp_segs(int v, bit blz);
        logic [27:0] r;
        int p;
        p = 1;
        for (int i = 0; i < 4; i++) begin
            if (blz && i > 0 && v < p) r[7*i +: 7] = 7'h7F;
            else r[7*i +: 7] = seg_of((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic logic get_busy(int inst);
        case (inst)
            0: return busy8;
            1: return busy_nb;
            default: return busy13;
        endcase
    endfunction

    function automatic logic [3:0] get_an(int inst);
        case (inst)
            0: return an8;
            1: return an_nb;
            default: return an13;
        endcase
    endfunction

    function automatic logic [6:0] get_seg(int inst);
        case (inst)
            0: return seg8;
            1: return seg_nb;
            default: return seg13;
        endcase
    endfunction

    function automatic int an_idx(logic [3:0] a);
        case (a)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    // Call right after driving stimulus; counts busy-high cycles until it drops.
    task automatic wait_conv(input int inst, output int hi, output bit ok);
        hi = 0;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (get_busy(inst)) hi++;
            else if (hi > 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic capture(input int inst, output logic [27:0] segs,
                           output bit ok);
        logic [3:0] seen;
        int d;
        seen = '0;
        segs = '1;
        ok   = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            d = an_idx(get_an(inst));
            if (d < 0) ok = 1'b0;
            else begin
                segs[7*d +: 7] = get_seg(inst);
                seen[d] = 1'b1;
            end
        end
        if (seen != 4'hF) ok = 1'b0;
    endtask

    task automatic test_reset();
        int hi;
        bit ok;
        logic [27:0] got;
        exp_t e;
        rst = 1'b1;
        v8  = '0;
        v13 = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if (an8 !== 4'hF) begin
            errors++;
            $display("FAIL rst_an: got %b want 1111", an8);
        end
        vectors++;
        if (seg8 !== 7'h7F) begin
            errors++;
            $display("FAIL rst_seg: got %h want 7f", seg8);
        end
        vectors++;
        if (busy8 !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy: got %b want 0", busy8);
        end
        vectors++;
        if (dp8 !== 1'b1) begin
            errors++;
            $display("FAIL rst_dp: got %b want 1", dp8);
        end
        sb.push_back('{0, exp_segs(0, 1'b1), 0});
        rst = 1'b0;
        wait_conv(0, hi, ok);
        vectors++;
        if (!ok || hi != 9) begin
            errors++;
            $display("FAIL rst_busy_len: got %0d done=%0d want 9", hi, ok);
        end
        capture(0, got, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || got !== e.segs) begin
            errors++;
            $display("FAIL rst_disp val=%0d: got %h want %h scan_ok=%0d",
                     e.val, got, e.segs, ok);
        end
    endtask

    task automatic test_convert_255();
        int hi;
        bit ok;
        logic [27:0] got;
        exp_t e;
        v8 = 8'd255;
        sb.push_back('{0, exp_segs(255, 1'b1), 255});
        sb.push_back('{1, exp_segs(255, 1'b0), 255});
        wait_conv(0, hi, ok);
        vectors++;
        if (!ok || hi != 9) begin
            errors++;
            $display("FAIL busy_255: got %0d done=%0d want 9", hi, ok);
        end
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            capture(e.inst, got, ok);
            vectors++;
            if (!ok || got !== e.segs) begin
                errors++;
                $display("FAIL disp_255 inst%0d: got %h want %h scan_ok=%0d",
                         e.inst, got, e.segs, ok);
            end
        end
    endtask

    task automatic test_change_mid_conv();
        int hi, d;
        bit ok, saw_a, rise, bad, phase_b;
        logic [27:0] got;
        exp_t ea, eb;
        v8 = 8'd12;
        sb.push_back('{0, exp_segs(12, 1'b1), 12});
        sb.push_back('{0, exp_segs(200, 1'b1), 200});
        repeat (3) @(posedge clk);
        @(negedge clk);
        v8 = 8'd200;
        wait_conv(0, hi, ok);
        vectors++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_first_done: got timeout want busy fall");
        end
        ea = sb.pop_front();
        eb = sb.pop_front();
        saw_a   = 1'b0;
        rise    = 1'b0;
        bad     = 1'b0;
        phase_b = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 60; k++) begin
            d = an_idx(an8);
            if (busy8) rise = 1'b1;
            if (d < 0) bad = 1'b1;
            else if (!phase_b) begin
                if (seg8 === ea.segs[7*d +: 7]) saw_a = 1'b1;
                else if (seg8 === eb.segs[7*d +: 7]) phase_b = 1'b1;
                else bad = 1'b1;
            end else if (seg8 !== eb.segs[7*d +: 7]) bad = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (!saw_a) begin
            errors++;
            $display("FAIL mid_first_12: got saw12=%0d want 1", saw_a);
        end
        vectors++;
        if (!rise) begin
            errors++;
            $display("FAIL mid_retrigger: got busy_rise=%0d want 1", rise);
        end
        vectors++;
        if (bad || !phase_b) begin
            errors++;
            $display("FAIL mid_no_mix: got bad=%0d reached200=%0d want 0/1",
                     bad, phase_b);
        end
        capture(0, got, ok);
        vectors++;
        if (!ok || got !== eb.segs) begin
            errors++;
            $display("FAIL disp_200: got %h want %h scan_ok=%0d",
                     got, eb.segs, ok);
        end
    endtask

    task automatic test_n13();
        int hi;
        bit ok;
        logic [27:0] got;
        exp_t e;
        int vals [2] = '{8191, 1000};
        for (int i = 0; i < 2; i++) begin
            v13 = 13'(vals[i]);
            sb.push_back('{2, exp_segs(vals[i], 1'b1), vals[i]});
            wait_conv(2, hi, ok);
            vectors++;
            if (!ok || hi != 14) begin
                errors++;
                $display("FAIL busy_n13 val=%0d: got %0d done=%0d want 14",
                         vals[i], hi, ok);
            end
            capture(2, got, ok);
            e = sb.pop_front();
            vectors++;
            if (!ok || got !== e.segs) begin
                errors++;
                $display("FAIL disp_n13 val=%0d: got %h want %h scan_ok=%0d",
                         e.val, got, e.segs, ok);
            end
        end
    endtask

    task automatic test_reset_mid_conv();
        int hi;
        bit ok;
        logic [27:0] got;
        exp_t e;
        v8 = 8'd99;
        sb.push_back('{0, exp_segs(99, 1'b1), 99});
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (an8 !== 4'hF || seg8 !== 7'h7F || busy8 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_vals: got an=%b seg=%h busy=%b want 1111/7f/0",
                     an8, seg8, busy8);
        end
        @(negedge clk);
        rst = 1'b0;
        wait_conv(0, hi, ok);
        vectors++;
        if (!ok || hi != 9) begin
            errors++;
            $display("FAIL midrst_busy: got %0d done=%0d want 9", hi, ok);
        end
        capture(0, got, ok);
        e = sb.pop_front();
        vectors++;
        if (!ok || got !== e.segs) begin
            errors++;
            $display("FAIL midrst_disp val=%0d: got %h want %h scan_ok=%0d",
                     e.val, got, e.segs, ok);
        end
    endtask

    task automatic test_hold();
        int busy_cnt, run, runs, dwell_bad, bad_an;
        bit first;
        logic [3:0] prev;
        busy_cnt  = 0;
        run       = 0;
        runs      = 0;
        dwell_bad = 0;
        bad_an    = 0;
        first     = 1'b1;
        @(negedge clk);
        prev = an8;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clk);
            if (busy8) busy_cnt++;
            if (an_idx(an8) < 0) bad_an++;
            if (an8 !== prev) begin
                if (!first && run != 3) dwell_bad++;
                if (!first) runs++;
                first = 1'b0;
                run   = 0;
                prev  = an8;
            end else run++;
        end
        vectors++;
        if (busy_cnt != 0) begin
            errors++;
            $display("FAIL hold_busy: got %0d busy cycles want 0", busy_cnt);
        end
        vectors++;
        if (dwell_bad != 0 || bad_an != 0 || runs < 200) begin
            errors++;
            $display("FAIL hold_dwell: got bad=%0d bad_an=%0d runs=%0d want 0/0/>=200",
                     dwell_bad, bad_an, runs);
        end
    endtask

    initial begin
        test_reset();
        test_convert_255();
        test_change_mid_conv();
        test_n13();
        test_reset_mid_conv();
        test_hold();
        vectors++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d left want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
